// File: rtl/ps2_rx_ctrl.sv
// ps2_rx_ctrl
//  SoC-side PS/2 receiver. Synchronises the keyboard's ps2_clk/ps2_dat lines,
//  deserialises 11-bit frames (start, 8 data bits LSB first, odd parity, stop)
//  and queues the received scan-code bytes in a small FIFO for the bus side.
//
//  Optional feature macro: PS2_RX_PARITY_CHECK_EN
//    defined   -> parity is checked; bad frames are dropped and flag parity_err
//    undefined -> parity bit is captured but ignored; no parity_err port
//
//  Ports
//    clock       in   system clock
//    resetn      in   asynchronous active-low reset
//    ps2_clk     in   PS/2 clock from device (asynchronous, idles high)
//    ps2_dat     in   PS/2 data from device (asynchronous, idles high)
//    rd_en       in   pop request, ignored when the FIFO is empty
//    clr_err     in   clears the sticky error flags
//    rd_data     out  FIFO head byte, 8'h00 when empty
//    empty       out  FIFO empty
//    count       out  number of bytes held
//    overflow    out  sticky: a valid byte was dropped because the FIFO was full
//    frame_err   out  sticky: bad stop bit or timeout abort
//    parity_err  out  sticky: frame dropped for bad parity (feature builds only)
module ps2_rx_ctrl #(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          ps2_clk,
    input  logic                          ps2_dat,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          frame_err
`ifdef PS2_RX_PARITY_CHECK_EN
   ,output logic                          parity_err
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);
    localparam logic [AW:0]   FULL_XOR = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic clk_meta, clk_sync, clk_prev, dat_meta, dat_sync;
    logic fall, rx_bit;

    state_t        state, state_next;
    logic [2:0]    bitcnt, bitcnt_next;
    logic [7:0]    sr, sr_next;
    logic          par, par_next;
    logic [TW-1:0] tocnt, tocnt_next;
    logic          push, stop_err, timeout, par_ok;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          full, pop, wr, ovf_evt;

    // Two-flop synchronisers on both lines plus a history flop on the clock
    // line so a falling edge can be detected; they reset to the idle level.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
        end
    end

    assign fall   = clk_prev & ~clk_sync;
    assign rx_bit = dat_sync;

`ifdef PS2_RX_PARITY_CHECK_EN
    assign par_ok = (par == ~^sr);
`else
    logic unused_par;
    assign par_ok     = 1'b1;
    assign unused_par = par;
`endif

    // Frame state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            bitcnt <= '0;
            sr     <= '0;
            par    <= 1'b0;
            tocnt  <= '0;
        end else begin
            state  <= state_next;
            bitcnt <= bitcnt_next;
            sr     <= sr_next;
            par    <= par_next;
            tocnt  <= tocnt_next;
        end
    end

    // Frame decoding advances only on ps2_clk fall events. The timeout counter
    // runs while a frame is in progress; a fall event on the final count still
    // counts as line activity and keeps the frame alive.
    always_comb begin
        state_next  = state;
        bitcnt_next = bitcnt;
        sr_next     = sr;
        par_next    = par;
        tocnt_next  = '0;
        push        = 1'b0;
        stop_err    = 1'b0;
        timeout     = 1'b0;

        case (state)
            IDLE: begin
                if (fall && !rx_bit) begin
                    state_next  = DATA;
                    bitcnt_next = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    sr_next[bitcnt] = rx_bit;
                    bitcnt_next     = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_next   = rx_bit;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_next = IDLE;
                    if (!rx_bit) begin
                        stop_err = 1'b1;
                    end else begin
                        push = par_ok;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (state != IDLE && !fall) begin
            if (tocnt == TO_LAST) begin
                timeout    = 1'b1;
                state_next = IDLE;
                sr_next    = '0;
            end else begin
                tocnt_next = tocnt + TO_ONE;
            end
        end
    end

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign empty   = (wptr == rptr);
    assign full    = ((wptr ^ rptr) == FULL_XOR);
    assign pop     = rd_en && !empty;
    assign wr      = push && (!full || pop);
    assign ovf_evt = push && full && !pop;
    assign count   = wptr - rptr;
    assign rd_data = empty ? 8'h00 : mem[rptr[AW-1:0]];

    // Byte storage and pointers; the extra pointer bit distinguishes full from empty.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr) begin
                mem[wptr[AW-1:0]] <= sr;
                wptr              <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Sticky error flags: a new error event on the same edge beats clr_err.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (stop_err || timeout) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

`ifdef PS2_RX_PARITY_CHECK_EN
    logic par_bad_evt;
    assign par_bad_evt = (state == STOP) && fall && rx_bit && !par_ok;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            parity_err <= 1'b0;
        end else if (par_bad_evt) begin
            parity_err <= 1'b1;
        end else if (clr_err) begin
            parity_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// tb_ps2_rx_ctrl
//  Self-checking bench for ps2_rx_ctrl: a table of single-frame vectors, hand
//  sequences for spurious edges, overflow, full push/pop and timeout, then a
//  randomized phase compared against a frame-level queue model.
module tb_ps2_rx_ctrl;

    localparam int DEPTH = 16;
`ifdef PS2_RX_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic       clock   = 1'b0;
    logic       resetn  = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       rd_en   = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       frame_err;
`ifdef PS2_RX_PARITY_CHECK_EN
    logic       parity_err;
`endif

    always #5 clock = ~clock;

    ps2_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(2048)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .frame_err (frame_err)
`ifdef PS2_RX_PARITY_CHECK_EN
       ,.parity_err(parity_err)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Frame-level reference: a byte queue plus the three sticky flags.
    logic [7:0] m_q[$];
    bit         m_ovf, m_ferr, m_perr;

    typedef struct {
        logic [7:0] data;
        bit         par;
        bit         stop;
        bit         exp_push;
        bit         exp_ferr;
        bit         exp_perr;
    } vec_t;

    vec_t tbl[8];

    function automatic bit odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " count"}, 32'(count), 32'(m_q.size()));
        check({tag, " empty"}, 32'(empty), 32'(m_q.size() == 0));
        check({tag, " rd_data"}, 32'(rd_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
        check({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, " frame_err"}, 32'(frame_err), 32'(m_ferr));
`ifdef PS2_RX_PARITY_CHECK_EN
        check({tag, " parity_err"}, 32'(parity_err), 32'(m_perr));
`endif
    endtask

    // Outcome of one complete frame; an optional pop and clear land on the
    // same edge as the stop-bit result, with the new error taking priority.
    task automatic model_frame(input logic [7:0] d, input bit p, input bit s, input bit do_pop, input bit do_clr);
        if (do_pop && m_q.size() > 0) void'(m_q.pop_front());
        if (do_clr) begin
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
            m_perr = 1'b0;
        end
        if (!s) m_ferr = 1'b1;
        else if (PCHK && (p != odd_par(d))) m_perr = 1'b1;
        else if (m_q.size() < DEPTH) m_q.push_back(d);
        else m_ovf = 1'b1;
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        m_q.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
    endtask

    // One PS/2 bit: data set while the clock is high, then a low phase. A
    // strobe raises rd_en/clr_err for the cycle the receiver acts on this fall.
    task automatic ps2_bit(input bit b, input int half, input bit s_pop, input bit s_clr);
        ps2_dat = b;
        repeat (half) @(negedge clock);
        ps2_clk = 1'b0;
        for (int i = 0; i < half; i++) begin
            @(negedge clock);
            rd_en   = s_pop && (i == 1);
            clr_err = s_clr && (i == 1);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit p, input bit s, input int half,
                              input bit do_pop, input bit do_clr);
        ps2_bit(1'b0, half, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], half, 1'b0, 1'b0);
        ps2_bit(p, half, 1'b0, 1'b0);
        ps2_bit(s, half, do_pop, do_clr);
        @(negedge clock);
        rd_en   = 1'b0;
        clr_err = 1'b0;
        ps2_dat = 1'b1;
        repeat (4) @(negedge clock);
        model_frame(d, p, s, do_pop, do_clr);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        @(negedge clock);
        clr_err = 1'b0;
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        bit         p, s, dp, dc;
        int         half;

        tbl[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'h12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h1C, 1'b1, 1'b1, !PCHK, 1'b0, PCHK};
        tbl[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        do_reset();
        check("reset count", 32'(count), 32'd0);
        check("reset empty", 32'(empty), 32'd1);
        check("reset rd_data", 32'(rd_data), 32'h0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);

        // Table of single frames at a 4-cycle bit period.
        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].data, tbl[i].par, tbl[i].stop, 2, 1'b0, 1'b0);
            check($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].exp_push));
            check($sformatf("vec%0d rd_data", i), 32'(rd_data),
                  tbl[i].exp_push ? 32'(tbl[i].data) : 32'h0);
            check($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'(tbl[i].exp_ferr));
`ifdef PS2_RX_PARITY_CHECK_EN
            check($sformatf("vec%0d parity_err", i), 32'(parity_err), 32'(tbl[i].exp_perr));
`endif
            if (tbl[i].exp_push) pop_one();
            clear_errors();
            check($sformatf("vec%0d empty after pop", i), 32'(empty), 32'd1);
            check($sformatf("vec%0d frame_err after clr", i), 32'(frame_err), 32'd0);
        end

        // Spurious clock pulse with data high: no frame starts.
        ps2_dat = 1'b1;
        ps2_clk = 1'b0;
        repeat (3) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clock);
        check("spurious count", 32'(count), 32'd0);
        check("spurious frame_err", 32'(frame_err), 32'd0);
        send_frame(8'h12, odd_par(8'h12), 1'b1, 2, 1'b0, 1'b0);
        check("after spurious rd_data", 32'(rd_data), 32'h12);
        check_model("after spurious");
        pop_one();

        // Seventeen frames into a sixteen-deep FIFO with no pops.
        do_reset();
        for (int v = 1; v <= 17; v++) send_frame(8'(v), odd_par(8'(v)), 1'b1, 2, 1'b0, 1'b0);
        check("fill count", 32'(count), 32'd16);
        check("fill overflow", 32'(overflow), 32'd1);
        for (int v = 1; v <= 16; v++) begin
            check($sformatf("drain %0d", v), 32'(rd_data), 32'(v));
            pop_one();
        end
        check("drained empty", 32'(empty), 32'd1);
        clear_errors();

        // Push while full with a pop on the same edge is accepted.
        for (int v = 0; v < 16; v++) send_frame(8'(8'h20 + v), odd_par(8'(8'h20 + v)), 1'b1, 2, 1'b0, 1'b0);
        send_frame(8'h30, odd_par(8'h30), 1'b1, 2, 1'b1, 1'b0);
        check("full push+pop count", 32'(count), 32'd16);
        check("full push+pop overflow", 32'(overflow), 32'd0);
        check("full push+pop head", 32'(rd_data), 32'h21);
        check_model("full push+pop");
        while (m_q.size() > 0) begin
            check("drain2", 32'(rd_data), 32'(m_q[0]));
            pop_one();
        end

        // Clear coinciding with a new error: the error wins.
        send_frame(8'h44, odd_par(8'h44), 1'b0, 2, 1'b0, 1'b0);
        send_frame(8'h45, odd_par(8'h45), 1'b1, 2, 1'b0, 1'b1);
        check("clr with good frame", 32'(frame_err), 32'd0);
        send_frame(8'h46, odd_par(8'h46), 1'b0, 2, 1'b0, 1'b1);
        check("clr with bad stop", 32'(frame_err), 32'd1);
        check_model("clr collision");
        pop_one();
        clear_errors();

        // Partial frame abandoned mid-byte is aborted by the timeout.
        ps2_bit(1'b0, 2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 2, 1'b0, 1'b0);
        ps2_dat = 1'b1;
        repeat (1000) @(negedge clock);
        check("timeout not yet", 32'(frame_err), 32'd0);
        repeat (1200) @(negedge clock);
        check("timeout frame_err", 32'(frame_err), 32'd1);
        m_ferr = 1'b1;
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, 2, 1'b0, 1'b0);
        check("after timeout rd_data", 32'(rd_data), 32'h5A);
        check_model("after timeout");

        // Randomized frames, pops and clears against the queue model.
        for (int it = 0; it < 80; it++) begin
            d    = 8'($urandom);
            p    = ($urandom_range(0, 7) == 0) ? !odd_par(d) : odd_par(d);
            s    = ($urandom_range(0, 9) != 0);
            half = $urandom_range(2, 4);
            dp   = 1'($urandom_range(0, 1));
            dc   = ($urandom_range(0, 5) == 0);
            send_frame(d, p, s, half, dp, dc);
            check_model($sformatf("rand%0d", it));
            if ($urandom_range(0, 3) == 0) begin
                pop_one();
                check_model($sformatf("rand%0d pop", it));
            end
            if (it % 25 == 24) clear_errors();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
